// File: rtl/sprite_scheduler_pkg.sv
// Shared video constants and the sprite record used by the sprite scheduler
// and its per-sprite hit-test slices.
//   SPR_SIZE        : sprite edge length in pixels (power of two)
//   H_ACTIVE        : visible pixels per line
//   V_ACTIVE        : visible lines per frame
//   COL_TRANSPARENT : mask colour meaning "show background"
//   sprite_t        : {x, y, vis, blink} for one sprite
package sprite_scheduler_pkg;

  localparam int unsigned SPR_SIZE        = 16;
  localparam int unsigned H_ACTIVE        = 640;
  localparam int unsigned V_ACTIVE        = 480;
  localparam logic [2:0]  COL_TRANSPARENT = 3'b000;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       vis;
    logic       blink;
  } sprite_t;

endpackage

// File: rtl/sprite_scheduler_if.sv
// Position-update port between game logic (master) and the sprite
// scheduler (slave). A transfer happens on upd_valid & upd_ready.
//   upd_valid  : request from game logic
//   upd_ready  : scheduler can accept this cycle
//   upd_id     : sprite index
//   upd_x/y    : sprite top-left corner
//   upd_vis    : sprite visible
//   upd_blink  : sprite flickers on the frame-counter blink bit
interface sprite_scheduler_if #(
  parameter int unsigned ID_W = 2
);

  logic            upd_valid;
  logic            upd_ready;
  logic [ID_W-1:0] upd_id;
  logic [9:0]      upd_x;
  logic [9:0]      upd_y;
  logic            upd_vis;
  logic            upd_blink;

  modport master (
    output upd_valid, upd_id, upd_x, upd_y, upd_vis, upd_blink,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_id, upd_x, upd_y, upd_vis, upd_blink,
    output upd_ready
  );

endinterface

// File: rtl/sprite_scheduler_hit.sv
// Per-sprite bounding-box test and local-coordinate subtract (sprite_hit).
//   spr         : committed sprite record
//   blink_phase : frame-counter bit that hides blinking sprites when 1
//   px, py      : current pixel
//   hit         : sprite visible and covers (px,py)
//   lx, ly      : pixel position inside the sprite, {upper zeros, px-x}
module sprite_hit #(
  parameter int unsigned SPR_SIZE = sprite_scheduler_pkg::SPR_SIZE
) (
  input  sprite_scheduler_pkg::sprite_t spr,
  input  logic                          blink_phase,
  input  logic [9:0]                    px,
  input  logic [9:0]                    py,
  output logic                          hit,
  output logic [9:0]                    lx,
  output logic [9:0]                    ly
);
  import sprite_scheduler_pkg::*;

  logic [10:0] px_w, py_w;
  logic [10:0] x_lo, y_lo, x_hi, y_hi;
  logic [9:0]  dx, dy;
  logic        in_x, in_y, shown;

  // One extra bit so a sprite hanging past column/row 1023 cannot wrap
  // around and hit pixels at the left/top edge.
  assign px_w = {1'b0, px};
  assign py_w = {1'b0, py};
  assign x_lo = {1'b0, spr.x};
  assign y_lo = {1'b0, spr.y};
  assign x_hi = x_lo + 11'(SPR_SIZE);
  assign y_hi = y_lo + 11'(SPR_SIZE);

  assign in_x  = (px_w >= x_lo) && (px_w < x_hi);
  assign in_y  = (py_w >= y_lo) && (py_w < y_hi);
  assign shown = spr.vis && !(spr.blink && blink_phase);
  assign hit   = shown && in_x && in_y;

  assign dx = px - spr.x;
  assign dy = py - spr.y;
  assign lx = dx & 10'(SPR_SIZE - 1);
  assign ly = dy & 10'(SPR_SIZE - 1);

endmodule

// File: rtl/sprite_scheduler.sv
// Sprite scheduler: shares one sprite-mask lookup between NUM_SPR sprites.
// Game logic posts positions into a shadow bank; frame_start copies the
// shadow bank into the active bank so sprite data is stable for a whole
// frame. Each pixel picks the lowest-index visible sprite covering it,
// drives its local coords to the mask mux and composites the returned
// colour over the background. Fixed 2-clk latency, no stalls.
//   clk, rst     : pixel clock, async active-high reset
//   frame_start  : one-clk pulse at start of vertical blank
//   px, py       : current pixel coordinates
//   bg_col       : background colour for (px,py)
//   upd          : position-update port (slave side)
//   mask_sel     : sprite whose mask feeds mask_col
//   mask_px/py   : local coords inside that sprite
//   mask_col     : combinational mask colour, 000 = transparent
//   out_col      : composited pixel colour
module sprite_scheduler #(
  parameter int unsigned NUM_SPR   = 4,
  parameter int unsigned SPR_SIZE  = sprite_scheduler_pkg::SPR_SIZE,
  parameter int unsigned BLINK_BIT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic [9:0]                 px,
  input  logic [9:0]                 py,
  input  logic [2:0]                 bg_col,
  sprite_scheduler_if.slave          upd,
  output logic [$clog2(NUM_SPR)-1:0] mask_sel,
  output logic [9:0]                 mask_px,
  output logic [9:0]                 mask_py,
  input  logic [2:0]                 mask_col,
  output logic [2:0]                 out_col
);
  import sprite_scheduler_pkg::*;

  localparam int unsigned ID_W = $clog2(NUM_SPR);

  sprite_t            shadow [NUM_SPR];
  sprite_t            active [NUM_SPR];
  logic [BLINK_BIT:0] frame_cnt;
  logic               ready_q;
  logic               fire;

  logic [NUM_SPR-1:0] hit_vec;
  logic [9:0]         lx [NUM_SPR];
  logic [9:0]         ly [NUM_SPR];

  logic               any_hit;
  logic [ID_W-1:0]    win_sel;
  logic [9:0]         win_lx, win_ly;

  logic               hit_d1;
  logic [2:0]         bg_d1;

  // Ready is refused in the commit cycle so a write can never race the
  // shadow->active copy; the requester simply holds it one more clock.
  assign upd.upd_ready = ready_q & ~frame_start;
  assign fire          = upd.upd_valid & upd.upd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q   <= 1'b0;
      frame_cnt <= '0;
      for (int unsigned i = 0; i < NUM_SPR; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      // Out-of-range ids complete the handshake but write nothing.
      if (fire && (32'(upd.upd_id) < NUM_SPR)) begin
        shadow[upd.upd_id] <= '{x:     upd.upd_x,
                                y:     upd.upd_y,
                                vis:   upd.upd_vis,
                                blink: upd.upd_blink};
      end
      if (frame_start) begin
        active    <= shadow;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_hit
    sprite_hit #(
      .SPR_SIZE (SPR_SIZE)
    ) u_hit (
      .spr         (active[g]),
      .blink_phase (frame_cnt[BLINK_BIT]),
      .px          (px),
      .py          (py),
      .hit         (hit_vec[g]),
      .lx          (lx[g]),
      .ly          (ly[g])
    );
  end

  // Scan from the lowest priority upward so the lowest index overwrites.
  always_comb begin
    any_hit = 1'b0;
    win_sel = '0;
    win_lx  = '0;
    win_ly  = '0;
    for (int unsigned i = NUM_SPR; i > 0; i--) begin
      if (hit_vec[i-1]) begin
        any_hit = 1'b1;
        win_sel = ID_W'(i - 1);
        win_lx  = lx[i-1];
        win_ly  = ly[i-1];
      end
    end
  end

  // S1 registers the lookup request; mask_col returns combinationally in
  // the following cycle and S2 composites it. Mask address holds on
  // pixels with no hit to avoid needless toggling of the mask mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_d1   <= 1'b0;
      bg_d1    <= '0;
      mask_sel <= '0;
      mask_px  <= '0;
      mask_py  <= '0;
      out_col  <= '0;
    end else begin
      hit_d1 <= any_hit;
      bg_d1  <= bg_col;
      if (any_hit) begin
        mask_sel <= win_sel;
        mask_px  <= win_lx;
        mask_py  <= win_ly;
      end
      out_col <= (hit_d1 && (mask_col != COL_TRANSPARENT)) ? mask_col : bg_d1;
    end
  end

endmodule

// File: tb/tb_sprite_scheduler.sv
`timescale 1ns/1ps
module tb_sprite_scheduler;

  localparam int NSPR = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic [9:0] px = '0;
  logic [9:0] py = '0;
  logic [2:0] bg_col = '0;
  logic [1:0] mask_sel;
  logic [9:0] mask_px, mask_py;
  logic [2:0] mask_col, out_col;

  sprite_scheduler_if #(.ID_W(2)) upd ();

  sprite_scheduler #(
    .NUM_SPR   (4),
    .SPR_SIZE  (16),
    .BLINK_BIT (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .px          (px),
    .py          (py),
    .bg_col      (bg_col),
    .upd         (upd),
    .mask_sel    (mask_sel),
    .mask_px     (mask_px),
    .mask_py     (mask_py),
    .mask_col    (mask_col),
    .out_col     (out_col)
  );

  always #5 clk = ~clk;

  // Mask ROM stand-in: transparent at local (3,3) and a sprinkling of
  // other texels, a different pattern per sprite.
  function automatic logic [2:0] rom(input int sel, input int lx, input int ly);
    int v;
    if (lx == 3 && ly == 3) return 3'b000;
    v = (lx + ly * 16 + sel * 37) % 11;
    if (v == 5) return 3'b000;
    return 3'((v % 7) + 1);
  endfunction

  assign mask_col = rom(int'(mask_sel), int'(mask_px) & 15, int'(mask_py) & 15);

  // Reference model state
  typedef struct { int x; int y; bit vis; bit blink; } spr_m;
  spr_m sh [NSPR];
  spr_m ac [NSPR];
  int   fcnt;
  bit   armed;
  int   last_sel, last_lx, last_ly;

  typedef struct { int due; int a; int b; int c; } exp_t;
  exp_t q_out[$];
  exp_t q_mask[$];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard when each
  // expectation falls due.
  exp_t me, oe;
  always @(negedge clk) begin
    if (q_mask.size() > 0 && q_mask[0].due == cyc) begin
      me = q_mask.pop_front();
      check("mask_sel", 32'(mask_sel), me.a);
      check("mask_px",  32'(mask_px),  me.b);
      check("mask_py",  32'(mask_py),  me.c);
    end
    if (q_out.size() > 0 && q_out[0].due == cyc) begin
      oe = q_out.pop_front();
      check("out_col", 32'(out_col), oe.a);
    end
  end

  // Per-cycle stimulus, held in these variables and applied by tick()
  int d_px, d_py, d_bg, d_id, d_x, d_y;
  bit d_fs, d_valid, d_vis, d_blink;
  bit xfer;

  task automatic model_clear();
    for (int i = 0; i < NSPR; i++) begin
      sh[i] = '{0, 0, 1'b0, 1'b0};
      ac[i] = '{0, 0, 1'b0, 1'b0};
    end
    fcnt = 0;
    last_sel = 0;
    last_lx = 0;
    last_ly = 0;
  endtask

  task automatic tick();
    bit hit, exp_rdy;
    int w, ocol;
    logic [2:0] mc;
    @(posedge clk);
    #1;
    armed = 1'b1;
    px = 10'(d_px);
    py = 10'(d_py);
    bg_col = 3'(d_bg);
    frame_start = d_fs;
    upd.upd_valid = d_valid;
    upd.upd_id = 2'(d_id);
    upd.upd_x = 10'(d_x);
    upd.upd_y = 10'(d_y);
    upd.upd_vis = d_vis;
    upd.upd_blink = d_blink;

    hit = 1'b0;
    w = 0;
    for (int i = 0; i < NSPR; i++) begin
      if (!hit && ac[i].vis && !(ac[i].blink && ((fcnt >> 3) & 1) == 1) &&
          d_px >= ac[i].x && d_px < ac[i].x + 16 &&
          d_py >= ac[i].y && d_py < ac[i].y + 16) begin
        hit = 1'b1;
        w = i;
      end
    end
    ocol = d_bg;
    if (hit) begin
      last_sel = w;
      last_lx = d_px - ac[w].x;
      last_ly = d_py - ac[w].y;
      mc = rom(w, last_lx, last_ly);
      if (mc != 3'b000) ocol = int'(mc);
    end
    q_mask.push_back('{cyc + 1, last_sel, last_lx, last_ly});
    q_out.push_back('{cyc + 2, ocol, 0, 0});

    exp_rdy = armed && !d_fs;
    #1;
    check("upd_ready", 32'(upd.upd_ready), 32'(exp_rdy));
    xfer = d_valid && exp_rdy;
    if (xfer && d_id < NSPR) sh[d_id] = '{d_x, d_y, d_vis, d_blink};
    if (d_fs) begin
      ac = sh;
      fcnt++;
    end
  endtask

  task automatic pix(input int x, input int y);
    d_px = x;
    d_py = y;
    d_bg = int'($urandom_range(0, 7));
    d_fs = 1'b0;
    d_valid = 1'b0;
    tick();
  endtask

  task automatic commit();
    d_fs = 1'b1;
    d_valid = 1'b0;
    d_bg = int'($urandom_range(0, 7));
    tick();
    d_fs = 1'b0;
  endtask

  task automatic update(input int id, input int x, input int y, input bit vis, input bit blink);
    bit done;
    done = 1'b0;
    d_id = id;
    d_x = x;
    d_y = y;
    d_vis = vis;
    d_blink = blink;
    for (int t = 0; t < 8 && !done; t++) begin
      d_valid = 1'b1;
      d_fs = 1'b0;
      d_px = int'($urandom_range(0, 1023));
      d_py = int'($urandom_range(0, 1023));
      d_bg = int'($urandom_range(0, 7));
      tick();
      done = xfer;
    end
    d_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL upd_timeout: got no transfer expected transfer within 8 cycles");
    end
  endtask

  task automatic do_reset(input int pre_ns);
    #(pre_ns);
    rst = 1'b1;
    frame_start = 1'b0;
    d_fs = 1'b0;
    d_valid = 1'b0;
    upd.upd_valid = 1'b0;
    q_out.delete();
    q_mask.delete();
    model_clear();
    armed = 1'b0;
    #1;
    check("rst_out_col",  32'(out_col),       0);
    check("rst_mask_sel", 32'(mask_sel),      0);
    check("rst_mask_px",  32'(mask_px),       0);
    check("rst_mask_py",  32'(mask_py),       0);
    check("rst_ready",    32'(upd.upd_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_before_clk", 32'(upd.upd_ready), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    d_px = 0; d_py = 0; d_bg = 0; d_id = 0; d_x = 0; d_y = 0;
    d_fs = 0; d_valid = 0; d_vis = 0; d_blink = 0; xfer = 0;
    upd.upd_valid = 1'b0; upd.upd_id = '0; upd.upd_x = '0; upd.upd_y = '0;
    upd.upd_vis = 1'b0; upd.upd_blink = 1'b0;

    do_reset(0);

    // Empty scene: background passes straight through
    for (int i = 0; i < 24; i++) pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));

    // Shadow write only shows after a commit
    update(0, 100, 50, 1'b1, 1'b0);
    pix(100, 50);
    commit();
    pix(100, 50); pix(115, 65); pix(116, 50); pix(99, 50);
    pix(100, 66); pix(115, 50); pix(107, 58);

    // Priority and no fall-through on transparency
    update(2, 200, 200, 1'b1, 1'b0);
    update(0, 200, 200, 1'b1, 1'b0);
    commit();
    pix(203, 203); pix(204, 203); pix(210, 212); pix(215, 215);

    // Update colliding with frame_start is held and lands next frame
    d_id = 3; d_x = 300; d_y = 100; d_vis = 1'b1; d_blink = 1'b0;
    d_valid = 1'b1; d_fs = 1'b1; d_px = 305; d_py = 105; d_bg = 2;
    tick();
    check("collide_no_xfer", 32'(xfer), 0);
    d_fs = 1'b0;
    tick();
    check("collide_xfer_next", 32'(xfer), 1);
    d_valid = 1'b0;
    pix(305, 105);
    commit();
    pix(305, 105); pix(300, 100);

    // Blinking sprite hanging off the right edge
    update(1, 1015, 300, 1'b1, 1'b1);
    for (int f = 0; f < 20; f++) begin
      commit();
      pix(1023, 300);
      pix(1015, 315);
      for (int p = 0; p <= 6; p++) pix(p, 300);
    end

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      d_fs = ($urandom_range(0, 39) == 0);
      d_valid = ($urandom_range(0, 3) == 0);
      d_id = int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: d_x = 100 + int'($urandom_range(0, 7));
        1: d_x = 1008 + int'($urandom_range(0, 15));
        2: d_x = int'($urandom_range(0, 7));
        default: d_x = int'($urandom_range(0, 1023));
      endcase
      d_y = 50 + int'($urandom_range(0, 9));
      d_vis = ($urandom_range(0, 4) != 0);
      d_blink = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) begin
        s = int'($urandom_range(0, 3));
        d_px = (ac[s].x + int'($urandom_range(0, 19)) + 1022) % 1024;
        d_py = (ac[s].y + int'($urandom_range(0, 19)) + 1022) % 1024;
      end else begin
        d_px = int'($urandom_range(0, 1023));
        d_py = int'($urandom_range(0, 1023));
      end
      d_bg = int'($urandom_range(0, 7));
      tick();
    end
    d_fs = 1'b0;
    d_valid = 1'b0;

    // Asynchronous reset in the middle of a cycle clears everything
    commit();
    pix(100, 50);
    do_reset(1);
    pix(100, 50); pix(203, 203); pix(1023, 300); pix(108, 55);
    update(0, 100, 50, 1'b1, 1'b0);
    pix(100, 50);
    commit();
    pix(100, 50); pix(112, 60);

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(q_out.size() + q_mask.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
